// File: rtl/sc_readback_receiver.sv
// sc_readback_receiver
//   Captures the MAROC slow-control readback stream (q_sc_in) while the SC
//   transmitter re-shifts a frame. Bits arrive LSB-first, so the first captured
//   bit lands at frame_out[0]. Every captured bit is compared against the frame
//   that was written (expected_in). The block reports the number of differing
//   bits, the index of the first differing bit, and an overall match flag.
//
// Ports
//   clk_in              SC bit clock; all logic runs on the rising edge
//   reset_in            synchronous active-high reset; overrides every input
//   start_in            arm or re-arm a capture (one-cycle pulse)
//   shift_en_in         high in each cycle that carries one SC bit
//   q_sc_in             serial readback bit; valid while shift_en_in=1
//   expected_in         written frame; held stable while busy
//   frame_out           captured frame
//   frame_valid_out     one-cycle pulse when a complete frame has been captured
//   busy_out            high while waiting for or capturing a frame
//   match_out           high in DONE when no bit differed
//   mismatch_count_out  number of differing bits; saturates at 2^CW-1
//   first_err_idx_out   index of the first differing bit; FRAME_BITS if none
//   state_out           current state (IDLE=0, ARMED=1, CAPTURE=2, DONE=3)
module sc_readback_receiver #(
    parameter int FRAME_BITS = 829,
    parameter int SKIP_BITS  = 0,
    parameter int CW         = 10
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    input  logic                  shift_en_in,
    input  logic                  q_sc_in,
    input  logic [FRAME_BITS-1:0] expected_in,
    output logic [FRAME_BITS-1:0] frame_out,
    output logic                  frame_valid_out,
    output logic                  busy_out,
    output logic                  match_out,
    output logic [CW-1:0]         mismatch_count_out,
    output logic [CW-1:0]         first_err_idx_out,
    output logic [1:0]            state_out
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [CW-1:0] CTR_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CTR_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] FRAME_IDX = CW'(FRAME_BITS);
    localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_BITS - 1);
    // Guarded so SKIP_BITS=0 does not produce a negative constant; ARMED is
    // never entered in that configuration.
    localparam logic [CW-1:0] SKIP_LAST = CW'((SKIP_BITS > 0) ? (SKIP_BITS - 1) : 0);
    localparam logic [1:0]    ARM_STATE = (SKIP_BITS == 0) ? ST_CAPTURE : ST_ARMED;

    logic [1:0]            state_r,     state_s;
    logic [CW-1:0]         skip_ctr_r,  skip_ctr_s;
    logic [CW-1:0]         bit_ctr_r,   bit_ctr_s;
    logic [FRAME_BITS-1:0] frame_r,     frame_s;
    logic [CW-1:0]         count_r,     count_s;
    logic [CW-1:0]         first_err_r, first_err_s;
    logic                  valid_r,     valid_s;
    logic                  match_r,     match_s;
    logic                  busy_r,      busy_s;
    logic                  bit_diff_s;

    // Next-state and datapath update for one SC bit clock cycle.
    always_comb begin
        state_s     = state_r;
        skip_ctr_s  = skip_ctr_r;
        bit_ctr_s   = bit_ctr_r;
        frame_s     = frame_r;
        count_s     = count_r;
        first_err_s = first_err_r;
        match_s     = match_r;
        valid_s     = 1'b0;
        bit_diff_s  = q_sc_in ^ expected_in[bit_ctr_r];

        if (start_in) begin
            // Start wins over a simultaneous shift; that bit is discarded.
            state_s     = ARM_STATE;
            skip_ctr_s  = CTR_ZERO;
            bit_ctr_s   = CTR_ZERO;
            frame_s     = {FRAME_BITS{1'b0}};
            count_s     = CTR_ZERO;
            first_err_s = FRAME_IDX;
            match_s     = 1'b0;
        end else begin
            case (state_r)
                ST_ARMED: begin
                    if (shift_en_in) begin
                        skip_ctr_s = skip_ctr_r + CTR_ONE;
                        if (skip_ctr_r == SKIP_LAST) begin
                            state_s = ST_CAPTURE;
                        end else begin
                            state_s = ST_ARMED;
                        end
                    end else begin
                        skip_ctr_s = skip_ctr_r;
                    end
                end
                ST_CAPTURE: begin
                    if (shift_en_in) begin
                        frame_s[bit_ctr_r] = q_sc_in;
                        bit_ctr_s          = bit_ctr_r + CTR_ONE;
                        if (bit_diff_s) begin
                            if (count_r != CNT_MAX) begin
                                count_s = count_r + CTR_ONE;
                            end else begin
                                count_s = count_r;
                            end
                            // A zero count means no earlier bit has differed.
                            if (count_r == CTR_ZERO) begin
                                first_err_s = bit_ctr_r;
                            end else begin
                                first_err_s = first_err_r;
                            end
                        end else begin
                            count_s = count_r;
                        end
                        if (bit_ctr_r == LAST_BIT) begin
                            state_s = ST_DONE;
                            valid_s = 1'b1;
                            match_s = (count_s == CTR_ZERO);
                        end else begin
                            state_s = ST_CAPTURE;
                        end
                    end else begin
                        bit_ctr_s = bit_ctr_r;
                    end
                end
                // IDLE and DONE ignore shift_en_in entirely.
                default: begin
                    state_s = state_r;
                end
            endcase
        end

        busy_s = (state_s == ST_ARMED) || (state_s == ST_CAPTURE);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_r     <= ST_IDLE;
            skip_ctr_r  <= CTR_ZERO;
            bit_ctr_r   <= CTR_ZERO;
            frame_r     <= {FRAME_BITS{1'b0}};
            count_r     <= CTR_ZERO;
            first_err_r <= FRAME_IDX;
            valid_r     <= 1'b0;
            match_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            skip_ctr_r  <= skip_ctr_s;
            bit_ctr_r   <= bit_ctr_s;
            frame_r     <= frame_s;
            count_r     <= count_s;
            first_err_r <= first_err_s;
            valid_r     <= valid_s;
            match_r     <= match_s;
            busy_r      <= busy_s;
        end
    end

    assign frame_out          = frame_r;
    assign frame_valid_out    = valid_r;
    assign busy_out           = busy_r;
    assign match_out          = match_r;
    assign mismatch_count_out = count_r;
    assign first_err_idx_out  = first_err_r;
    assign state_out          = state_r;

endmodule
